iter_div: RTL and testbench
===========================

ITER_DIV -- requirements
Module: iter_div

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk (clock) and resetn (async active-low reset), as used throughout the codebase.
REQ-002 The block SHALL have no parameters; all data widths are fixed at 32 bits.
REQ-003 It SHALL provide these ports:
- clk  input  1: clock; all state changes on its rising edge.
- resetn  input  1: asynchronous active-low reset.
- div  input  1: start request, sampled only in IDLE.
- div_signed  input  1: 1 = two's-complement divide, 0 = unsigned.
- dividend  input  32: dividend, captured on the accepting edge.
- divisor  input  32: divisor, captured on the accepting edge.
- cancel  input  1: pipeline-flush abort.
- quotient  output  32: quotient result.
- remainder  output  32: remainder result.
- busy  output  1: operation in progress (CALC or DONE).
- complete  output  1: one-cycle result-valid pulse.

Function
REQ-004 The state machine SHALL have exactly three states: IDLE, CALC and DONE.
REQ-005 In IDLE, div=1 and cancel=0 at a rising edge SHALL accept a request:
- capture div_signed, the magnitudes of both operands, and the result sign bits;
- clear the 6-bit iteration counter;
- go to CALC.
REQ-006 In CALC, each rising edge SHALL perform one radix-2 restoring step on a 64-bit partial remainder and increment the counter; after the 32nd step the state SHALL be DONE.
REQ-007 In DONE, the next rising edge SHALL return the state to IDLE unconditionally.
REQ-008 Latency: with the accepting edge as edge k, complete SHALL be high during exactly the one cycle that follows edge k+32, and low at all other times.
REQ-009 busy SHALL be high in CALC and DONE, and low in IDLE.
REQ-010 quotient and remainder SHALL be updated on entry to DONE and held stable until the next DONE entry or reset.
REQ-011 Signed mode SHALL give the quotient the sign of dividend XOR divisor and the remainder the sign of the dividend, with the quotient truncated toward zero.
REQ-012 Unsigned mode SHALL treat both operands as 0..2^32-1.
REQ-013 A divide by zero, in either mode, SHALL still take the full latency and produce quotient = 0xFFFFFFFF and remainder = the original dividend.
REQ-014 Signed 0x80000000 / 0xFFFFFFFF SHALL produce quotient 0x80000000 and remainder 0x00000000, with no trap.
REQ-015 div asserted while busy=1 SHALL be ignored: no queueing and no effect on the running operation.
REQ-016 Back-to-back operation: the earliest a new request can be accepted is the edge ending IDLE, i.e. one cycle after the DONE cycle.
REQ-017 cancel=1 at a rising edge in CALC or DONE SHALL move the state to IDLE with busy low next cycle.
- complete SHALL NOT assert for the aborted operation.
- quotient and remainder SHALL keep their previous values.
REQ-018 cancel=1 together with div=1 in IDLE SHALL NOT accept the request; cancel wins.
REQ-019 Operand inputs SHALL be ignored after the accepting edge; changing them mid-operation SHALL NOT affect the result.

Reset
REQ-020 resetn=0 SHALL immediately, without waiting for clk, force:
- state to IDLE;
- busy=0 and complete=0;
- quotient=0x00000000 and remainder=0x00000000;
- the counter and internal operand registers to 0.
REQ-021 Reset asserted mid-operation SHALL discard that operation; no complete pulse SHALL follow the release of reset.
REQ-022 The first request SHALL be accepted no earlier than the first rising edge at which resetn is sampled high.

Verification
REQ-023 Unsigned divide: div_signed=0, 100 / 7 -> complete one cycle after edge k+32, quotient=0x0000000E, remainder=0x00000002; also 0xFFFFFFFF / 0x10 -> quotient 0x0FFFFFFF, remainder 0x0000000F.
REQ-024 Signed divide: div_signed=1, 0xFFFFFFF9 (-7) / 2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; also 7 / 0xFFFFFFFE -> quotient 0xFFFFFFFD, remainder 0x00000001; also the overflow case -> 0x80000000 / 0.
REQ-025 Divide by zero: 0x12345678 / 0, both modes -> quotient=0xFFFFFFFF, remainder=0x12345678, same latency.
REQ-026 Start while busy: accept 100/7, then pulse div with 50/5 at edge k+10 -> only one complete, result 14/2; 50/5 accepted only when re-issued in IDLE.
REQ-027 Cancel and reset: cancel at edge k+5 -> busy low after that edge, no complete within 40 cycles, outputs unchanged; resetn low at edge k+20 of another operation -> outputs zero immediately, no complete after release.
REQ-028 Back-to-back: issue a new div the cycle after complete -> accepted at the following edge, second complete exactly 34 cycles after the first.

Source files
------------

// File: rtl/iter_div.sv
// iter_div: 32-bit iterative radix-2 restoring divider, signed or unsigned.
// One quotient bit is resolved per clock; results appear 32 cycles after
// the request is accepted.
//
// Ports:
//   clk        - clock, rising edge
//   resetn     - asynchronous active-low reset
//   div        - start request, honoured only when idle
//   div_signed - 1: two's-complement divide, 0: unsigned
//   dividend   - dividend, captured on the accepting edge
//   divisor    - divisor, captured on the accepting edge
//   cancel     - abort the running operation (also blocks a start)
//   quotient   - quotient, updated when a divide finishes
//   remainder  - remainder, updated when a divide finishes
//   busy       - operation in progress
//   complete   - one-cycle result-valid pulse
module iter_div (
    input  logic        clk,
    input  logic        resetn,
    input  logic        div,
    input  logic        div_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        cancel,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        busy,
    output logic        complete
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [5:0]  r_cnt;
    logic [63:0] r_acc;       // {partial remainder, dividend/quotient bits}
    logic [31:0] r_dvs;       // divisor magnitude
    logic        r_signed;
    logic        r_q_sgn;     // dividend sign XOR divisor sign
    logic        r_r_sgn;     // dividend sign
    logic [31:0] r_quotient;
    logic [31:0] r_remainder;

    logic        w_accept;
    logic        w_step;
    logic        w_finish;
    logic [31:0] w_dvd_mag;
    logic [31:0] w_dvs_mag;
    logic [32:0] w_hi;
    logic [32:0] w_diff;
    logic        w_ge;
    logic [63:0] w_acc_nxt;
    logic [31:0] w_q_res;
    logic [31:0] w_r_res;

    assign w_accept = (r_state == S_IDLE) && div && !cancel;
    assign w_step   = (r_state == S_CALC) && !cancel;
    assign w_finish = w_step && (r_cnt == 6'd31);

    // 0x80000000 negates to itself, which is still the correct unsigned magnitude.
    assign w_dvd_mag = (div_signed && dividend[31]) ? (~dividend + 32'd1) : dividend;
    assign w_dvs_mag = (div_signed && divisor[31])  ? (~divisor  + 32'd1) : divisor;

    // The shifted remainder needs 33 bits: it can reach 2*divisor - 1.
    assign w_hi      = r_acc[63:31];
    assign w_diff    = w_hi - {1'b0, r_dvs};
    assign w_ge      = !w_diff[32];
    assign w_acc_nxt = {(w_ge ? w_diff[31:0] : w_hi[31:0]), r_acc[30:0], w_ge};

    // A zero divisor yields all-ones quotient bits and leaves the dividend
    // magnitude as remainder; re-signing that gives back the original dividend.
    // The quotient is forced to all ones so sign fix-up cannot disturb it.
    always_comb begin
        w_q_res = w_acc_nxt[31:0];
        w_r_res = w_acc_nxt[63:32];
        if (r_signed && r_q_sgn)
            w_q_res = ~w_acc_nxt[31:0] + 32'd1;
        if (r_signed && r_r_sgn)
            w_r_res = ~w_acc_nxt[63:32] + 32'd1;
        if (r_dvs == '0)
            w_q_res = '1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        complete    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept)
                    w_state_nxt = S_CALC;
            end
            S_CALC: begin
                busy = 1'b1;
                if (cancel)
                    w_state_nxt = S_IDLE;
                else if (r_cnt == 6'd31)
                    w_state_nxt = S_DONE;
            end
            S_DONE: begin
                busy        = 1'b1;
                complete    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt       <= '0;
            r_acc       <= '0;
            r_dvs       <= '0;
            r_signed    <= 1'b0;
            r_q_sgn     <= 1'b0;
            r_r_sgn     <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else begin
            if (w_accept) begin
                r_cnt    <= '0;
                r_acc    <= {32'd0, w_dvd_mag};
                r_dvs    <= w_dvs_mag;
                r_signed <= div_signed;
                r_q_sgn  <= dividend[31] ^ divisor[31];
                r_r_sgn  <= dividend[31];
            end else if (w_step) begin
                r_cnt <= r_cnt + 6'd1;
                r_acc <= w_acc_nxt;
            end
            if (w_finish) begin
                r_quotient  <= w_q_res;
                r_remainder <= w_r_res;
            end
        end
    end

    assign quotient  = r_quotient;
    assign remainder = r_remainder;

endmodule

// File: tb/tb_iter_div.sv
// Testbench for iter_div: scoreboard of expected results checked on each
// complete pulse, including the completion edge (accept edge + 32).
module tb_iter_div;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        div = 1'b0;
    logic        div_signed = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        cancel = 1'b0;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        busy;
    logic        complete;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        int          k;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          edge_cnt = 0;
    logic [31:0] last_q = '0;
    logic [31:0] last_r = '0;

    iter_div dut (
        .clk       (clk),
        .resetn    (resetn),
        .div       (div),
        .div_signed(div_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .cancel    (cancel),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .complete  (complete)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at edge %0d", tag, got, exp, edge_cnt);
        end
    endtask

    function automatic exp_t model(input logic s, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.k = 0;
        if (b == 32'd0) begin
            e.q = 32'hFFFFFFFF;
            e.r = a;
        end else if (s && a == 32'h80000000 && b == 32'hFFFFFFFF) begin
            e.q = 32'h80000000;
            e.r = 32'h0;
        end else if (s) begin
            e.q = $signed(a) / $signed(b);
            e.r = $signed(a) % $signed(b);
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin : mon
        exp_t e;
        if (complete) begin
            if (sb.size() == 0) begin
                check("spurious_complete", 32'(complete), 32'd0);
            end else begin
                e = sb.pop_front();
                check("quotient", quotient, e.q);
                check("remainder", remainder, e.r);
                check("latency", edge_cnt, e.k + 32);
                last_q = e.q;
                last_r = e.r;
            end
        end else if (sb.size() != 0 && edge_cnt > sb[0].k + 32) begin
            check("missing_complete", 32'(complete), 32'd1);
            e = sb.pop_front();
        end
    end

    // Called at a falling edge with the DUT idle; returns one falling edge later.
    task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input logic [31:0] eq, input logic [31:0] er);
        exp_t e;
        div        = 1'b1;
        div_signed = s;
        dividend   = a;
        divisor    = b;
        if (push) begin
            e.q = eq;
            e.r = er;
            e.k = edge_cnt + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        div        = 1'b0;
        dividend   = $urandom;
        divisor    = $urandom;
        div_signed = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done(output int at);
        int n = 0;
        while (!complete && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("wait_done", 32'(complete), 32'd1);
        at = edge_cnt;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int   t1, t2;
        exp_t m;
        logic s;
        logic [31:0] a, b;

        // Reset state, and a request held during reset must not start anything.
        repeat (2) @(negedge clk);
        check("rst_quotient", quotient, 32'h0);
        check("rst_remainder", remainder, 32'h0);
        check("rst_complete", 32'(complete), 32'd0);
        div = 1'b1;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        div = 1'b0;
        resetn = 1'b1;
        @(negedge clk);

        // Directed vectors
        issue(1'b0, 32'd100, 32'd7, 1, 32'h0000000E, 32'h00000002);
        wait_done(t1); @(negedge clk);
        issue(1'b0, 32'hFFFFFFFF, 32'h10, 1, 32'h0FFFFFFF, 32'h0000000F);
        wait_done(t1); @(negedge clk);
        issue(1'b1, 32'hFFFFFFF9, 32'd2, 1, 32'hFFFFFFFD, 32'hFFFFFFFF);
        wait_done(t1); @(negedge clk);
        issue(1'b1, 32'd7, 32'hFFFFFFFE, 1, 32'hFFFFFFFD, 32'h00000001);
        wait_done(t1); @(negedge clk);
        issue(1'b1, 32'h80000000, 32'hFFFFFFFF, 1, 32'h80000000, 32'h00000000);
        wait_done(t1); @(negedge clk);
        issue(1'b0, 32'h12345678, 32'd0, 1, 32'hFFFFFFFF, 32'h12345678);
        wait_done(t1); @(negedge clk);
        issue(1'b1, 32'h12345678, 32'd0, 1, 32'hFFFFFFFF, 32'h12345678);
        wait_done(t1); @(negedge clk);
        issue(1'b1, 32'hEDCBA988, 32'd0, 1, 32'hFFFFFFFF, 32'hEDCBA988);
        wait_done(t1); @(negedge clk);

        // Random operands against the arithmetic model
        for (int i = 0; i < 8; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            m = model(s, a, b);
            issue(s, a, b, 1, m.q, m.r);
            wait_done(t1); @(negedge clk);
        end

        // Start while busy is ignored
        issue(1'b0, 32'd100, 32'd7, 1, 32'd14, 32'd2);
        repeat (9) @(negedge clk);
        div = 1'b1; dividend = 32'd50; divisor = 32'd5; div_signed = 1'b0;
        @(negedge clk);
        div = 1'b0;
        wait_done(t1);
        repeat (3) @(negedge clk);
        check("ignored_busy", 32'(busy), 32'd0);
        issue(1'b0, 32'd50, 32'd5, 1, 32'd10, 32'd0);
        wait_done(t1);

        // Back-to-back: new request in the IDLE cycle after DONE
        @(negedge clk);
        issue(1'b0, 32'd1000, 32'd3, 1, 32'd333, 32'd1);
        wait_done(t2);
        check("b2b_gap", 32'(t2 - t1), 32'd34);
        @(negedge clk);

        // cancel together with div in IDLE: cancel wins
        div = 1'b1; cancel = 1'b1; dividend = 32'd9; divisor = 32'd3;
        @(negedge clk);
        div = 1'b0; cancel = 1'b0;
        check("cancel_idle_busy", 32'(busy), 32'd0);
        @(negedge clk);

        // Cancel at edge k+5
        issue(1'b0, 32'd100, 32'd7, 0, 32'd0, 32'd0);
        repeat (4) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel_busy", 32'(busy), 32'd0);
        repeat (40) @(negedge clk);
        check("cancel_quotient", quotient, last_q);
        check("cancel_remainder", remainder, last_r);

        // Asynchronous reset at edge k+20 of another operation
        issue(1'b1, 32'hFFFFFF00, 32'd3, 0, 32'd0, 32'd0);
        repeat (19) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        check("arst_quotient", quotient, 32'h0);
        check("arst_remainder", remainder, 32'h0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_complete", 32'(complete), 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (40) @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_quotient", quotient, 32'h0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
